// File: rtl/halloween_pkg.sv
// Shared definitions for the Halloween program encoder: opcode values,
// opcode legality check and the assembler state type.
package halloween_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SLOTS = 4;

  localparam logic [3:0] OP_ON        = 4'h0;
  localparam logic [3:0] OP_RESET     = 4'h1;
  localparam logic [3:0] OP_NOOP      = 4'h2;
  localparam logic [3:0] OP_FOG       = 4'h3;
  localparam logic [3:0] OP_GREEN     = 4'h4;
  localparam logic [3:0] OP_PURPLE    = 4'h5;
  localparam logic [3:0] OP_ORANGE    = 4'h6;
  localparam logic [3:0] OP_SCREAMING = 4'h8;
  localparam logic [3:0] OP_CACKLING  = 4'h9;
  localparam logic [3:0] OP_BOO       = 4'hA;
  localparam logic [3:0] OP_WAVEHANDS = 4'hC;
  localparam logic [3:0] OP_MOVEJAW   = 4'hD;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FLUSH_WAIT
  } asm_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      4'h7, 4'hB, 4'hE, 4'hF: return 1'b0;
      default:                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/halloween_program_encoder_if.sv
// Command-side and sequencer-side signals of the program encoder.
//   slave  : encoder view (takes opcodes/flush/word_ready, drives the rest)
//   master : command source / sequencer view
interface halloween_program_encoder_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned SLOTS = 4
);
  logic [OP_W-1:0]       op_in;
  logic                  op_valid;
  logic                  op_ready;
  logic                  flush;
  logic [OP_W*SLOTS-1:0] word_out;
  logic                  word_valid;
  logic                  word_ready;
  logic [2:0]            slot_count;
  logic [2:0]            fifo_count;
  logic                  illegal;

  modport slave (
    input  op_in, op_valid, flush, word_ready,
    output op_ready, word_out, word_valid, slot_count, fifo_count, illegal
  );

  modport master (
    output op_in, op_valid, flush, word_ready,
    input  op_ready, word_out, word_valid, slot_count, fifo_count, illegal
  );
endinterface

// File: rtl/program_fifo.sv
// Synchronous FIFO for finished program words.
//   push/push_data : write (ignored when full)
//   pop            : read  (ignored when empty)
//   head/valid     : registered head entry, non-empty flag
//   full/count     : occupancy
module program_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/halloween_program_encoder.sv
// Packs 4-bit decoration opcodes into program words (slot 0 in the low
// nibble), closes partial words on flush with NOOP padding, and buffers
// finished words for the sequencer.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : opcode handshake, flush, word handshake, status outputs
module halloween_program_encoder #(
  parameter int unsigned OP_W       = halloween_pkg::OP_W,
  parameter int unsigned SLOTS      = halloween_pkg::SLOTS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  halloween_program_encoder_if.slave  bus
);
  import halloween_pkg::*;

  localparam int unsigned WW = OP_W * SLOTS;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  asm_state_e    state_q, state_d;
  logic [2:0]    slot_q, slot_d, cur_slot;
  logic [WW-1:0] word_q, word_d, cur_word, push_word;
  logic          illegal_q, illegal_d;
  logic          push, fifo_full, accept, op_is_on;
  logic [CW-1:0] fifo_cnt;

  assign op_is_on = (bus.op_in == OP_W'(OP_ON));
  assign bus.op_ready = (state_q != FLUSH_WAIT) &&
                        (!fifo_full || (slot_q < 3'(SLOTS - 1) && !(slot_q == '0 && op_is_on)));
  assign accept = bus.op_valid && bus.op_ready;

  // The opcode is folded into cur_word/cur_slot first so a same-cycle flush
  // pads the word that already contains it.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    word_d    = word_q;
    illegal_d = 1'b0;
    push      = 1'b0;
    push_word = '0;
    cur_slot  = slot_q;
    cur_word  = word_q;
    if (state_q == FLUSH_WAIT) begin
      if (!fifo_full) begin
        push      = 1'b1;
        push_word = word_q;
        for (int unsigned i = 0; i < SLOTS; i++)
          if (i >= 32'(slot_q)) push_word[i*OP_W +: OP_W] = OP_W'(OP_NOOP);
        slot_d  = '0;
        word_d  = '0;
        state_d = EMPTY;
      end
    end else begin
      if (accept) begin
        if (!is_legal_op(4'(bus.op_in))) begin
          illegal_d = 1'b1;
        end else if (op_is_on) begin
          if (slot_q == '0) push = 1'b1;
          else              illegal_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < SLOTS; i++)
            if (i == 32'(slot_q)) cur_word[i*OP_W +: OP_W] = bus.op_in;
          if (slot_q == 3'(SLOTS - 1)) begin
            push      = 1'b1;
            push_word = cur_word;
            cur_slot  = '0;
            cur_word  = '0;
          end else begin
            cur_slot = slot_q + 3'd1;
          end
        end
      end
      state_d = (cur_slot == '0) ? EMPTY : FILL;
      if (bus.flush && cur_slot != '0) begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_word = cur_word;
          for (int unsigned i = 0; i < SLOTS; i++)
            if (i >= 32'(cur_slot)) push_word[i*OP_W +: OP_W] = OP_W'(OP_NOOP);
          cur_slot = '0;
          cur_word = '0;
          state_d  = EMPTY;
        end else begin
          state_d = FLUSH_WAIT;
        end
      end
      slot_d = cur_slot;
      word_d = cur_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      slot_q    <= '0;
      word_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      word_q    <= word_d;
      illegal_q <= illegal_d;
    end
  end

  program_fifo #(
    .W     (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (bus.word_ready),
    .head      (bus.word_out),
    .valid     (bus.word_valid),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

  assign bus.fifo_count = 3'(fifo_cnt);
  assign bus.slot_count = slot_q;
  assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_halloween_program_encoder.sv
module tb_halloween_program_encoder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  halloween_program_encoder_if #(.OP_W(4), .SLOTS(4)) bus ();

  halloween_program_encoder #(
    .OP_W       (4),
    .SLOTS      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op);
    bus.op_in    = op;
    bus.op_valid = 1'b1;
    step();
    bus.op_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b0;
    bus.op_in      = 4'h2;
    bus.op_valid   = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b1;
    step();
    step();
    check("rst_slot",    32'(bus.slot_count), 32'd0);
    check("rst_fifo",    32'(bus.fifo_count), 32'd0);
    check("rst_valid",   32'(bus.word_valid), 32'd0);
    check("rst_word",    32'(bus.word_out),   32'h0);
    check("rst_illegal", 32'(bus.illegal),    32'd0);
    rst = 1'b1;
    step();
    check("rst_ready",   32'(bus.op_ready),   32'd1);

    // Pack four opcodes
    send(4'h3); send(4'h4); send(4'h5);
    check("pack_slot3",  32'(bus.slot_count), 32'd3);
    check("pack_novalid", 32'(bus.word_valid), 32'd0);
    send(4'h8);
    check("pack_valid",  32'(bus.word_valid), 32'd1);
    check("pack_word",   32'(bus.word_out),   32'h8543);
    check("pack_slot0",  32'(bus.slot_count), 32'd0);
    step();
    check("pack_pop",    32'(bus.fifo_count), 32'd0);

    // Flush a partial word, then flush with nothing assembled
    send(4'h4); send(4'h6);
    check("flush_slot2", 32'(bus.slot_count), 32'd2);
    pulse_flush();
    check("flush_word",  32'(bus.word_out),   32'h2264);
    check("flush_valid", 32'(bus.word_valid), 32'd1);
    check("flush_slot0", 32'(bus.slot_count), 32'd0);
    step();
    pulse_flush();
    check("flush0_fifo", 32'(bus.fifo_count), 32'd0);
    check("flush0_valid", 32'(bus.word_valid), 32'd0);

    // Illegal opcode
    send(4'h7);
    check("ill_pulse",   32'(bus.illegal),    32'd1);
    check("ill_slot",    32'(bus.slot_count), 32'd0);
    check("ill_noword",  32'(bus.word_valid), 32'd0);
    step();
    check("ill_clear",   32'(bus.illegal),    32'd0);

    // ON at slot 0
    send(4'h0);
    check("on0_valid",   32'(bus.word_valid), 32'd1);
    check("on0_word",    32'(bus.word_out),   32'h0000);
    check("on0_slot",    32'(bus.slot_count), 32'd0);
    step();

    // ON at slot 2 is dropped, partial word stays intact
    send(4'hA); send(4'h9); send(4'h0);
    check("on2_illegal", 32'(bus.illegal),    32'd1);
    check("on2_slot",    32'(bus.slot_count), 32'd2);
    pulse_flush();
    check("on2_word",    32'(bus.word_out),   32'h229A);
    step();
    check("on2_drain",   32'(bus.fifo_count), 32'd0);

    // Backpressure and pending flush
    bus.word_ready = 1'b0;
    send(4'h0); send(4'h0); send(4'h0); send(4'h0);
    check("bp_full",     32'(bus.fifo_count), 32'd4);
    check("bp_on_block", 32'(bus.op_ready),   32'd0);
    bus.op_in = 4'h3;
    #1;
    check("bp_fog_ok",   32'(bus.op_ready),   32'd1);
    send(4'h3); send(4'h4); send(4'h5);
    check("bp_slot3",    32'(bus.slot_count), 32'd3);
    check("bp_ready0",   32'(bus.op_ready),   32'd0);
    pulse_flush();
    bus.op_in = 4'h3;
    #1;
    check("fw_ready0",   32'(bus.op_ready),   32'd0);
    check("fw_fifo",     32'(bus.fifo_count), 32'd4);
    check("fw_slot",     32'(bus.slot_count), 32'd3);
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
    check("fw_pop",      32'(bus.fifo_count), 32'd3);
    step();
    check("fw_push",     32'(bus.fifo_count), 32'd4);
    check("fw_slot0",    32'(bus.slot_count), 32'd0);
    check("fw_ready1",   32'(bus.op_ready),   32'd1);
    bus.word_ready = 1'b1;
    step(); step(); step();
    check("fw_last_cnt", 32'(bus.fifo_count), 32'd1);
    check("fw_last_word", 32'(bus.word_out),  32'h2543);
    step();
    check("fw_drain",    32'(bus.fifo_count), 32'd0);

    // Simultaneous push and pop at fifo_count 2
    bus.word_ready = 1'b0;
    send(4'h0);
    send(4'h3); send(4'h4); send(4'h5); send(4'h8);
    send(4'hA); send(4'hA); send(4'hA);
    check("sim_pre",     32'(bus.fifo_count), 32'd2);
    check("sim_head0",   32'(bus.word_out),   32'h0000);
    bus.word_ready = 1'b1;
    send(4'h9);
    check("sim_cnt",     32'(bus.fifo_count), 32'd2);
    check("sim_head1",   32'(bus.word_out),   32'h8543);
    step();
    check("sim_head2",   32'(bus.word_out),   32'h9AAA);
    check("sim_cnt1",    32'(bus.fifo_count), 32'd1);
    step();
    check("sim_empty",   32'(bus.word_valid), 32'd0);

    // Asynchronous reset mid-word
    bus.word_ready = 1'b0;
    send(4'h0);
    send(4'hA); send(4'h4);
    check("mid_slot",    32'(bus.slot_count), 32'd2);
    check("mid_fifo",    32'(bus.fifo_count), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_slot",     32'(bus.slot_count), 32'd0);
    check("ar_fifo",     32'(bus.fifo_count), 32'd0);
    check("ar_valid",    32'(bus.word_valid), 32'd0);
    check("ar_word",     32'(bus.word_out),   32'h0);
    check("ar_illegal",  32'(bus.illegal),    32'd0);
    step();
    rst = 1'b1;
    bus.word_ready = 1'b1;
    bus.op_in = 4'hA;
    #1;
    check("ar_ready",    32'(bus.op_ready),   32'd1);
    send(4'hA); send(4'h4); send(4'h1); send(4'h2);
    check("ar_word2",    32'(bus.word_out),   32'h214A);
    check("ar_valid2",   32'(bus.word_valid), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/halloween_program_encoder.md
Name: halloween_program_encoder

Overview:
- Builds the 16-bit program words that the decoration sequencer consumes. Four 4-bit opcodes per word; channel 0 is bits [3:0] and executes first.
- Sits between the button/command source and the sequencer.
- Accepts one opcode per handshake, validates it, packs it into the next slot, and buffers finished words in a small FIFO.
- Presents each word to the sequencer with a valid/ready handshake.

Parameters:
- OP_W, 4, opcode width in bits.
- SLOTS, 4, opcodes per program word; word width is OP_W*SLOTS.
- FIFO_DEPTH, 4, number of completed words buffered; must be a power of 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_in  in  OP_W  opcode offered by the command source.
- op_valid  in  1  op_in is valid this cycle.
- op_ready  out  1  encoder accepts op_in this cycle.
- flush  in  1  single-cycle request to close a partial word.
- word_out  out  OP_W*SLOTS  FIFO head word.
- word_valid  out  1  word_out is valid (FIFO not empty).
- word_ready  in  1  sequencer takes word_out this cycle.
- slot_count  out  3  slots filled in the word being assembled (0..3).
- fifo_count  out  3  words buffered (0..FIFO_DEPTH).
- illegal  out  1  one-cycle pulse when an opcode is accepted and then dropped.

Behaviour:
- Opcode legality:
  - Legal: 0000 ON, 0001 RESET, 0010 NOOP, 0011 FOG, 0100 GREEN, 0101 PURPLE, 0110 ORANGE, 1000 SCREAMING, 1001 CACKLING, 1010 BOO, 1100 WAVEHANDS, 1101 MOVEJAW.
  - Illegal: 0111, 1011, 1110, 1111.
- Accept condition: op_valid && op_ready.
- op_ready is combinational: !fifo_full || (slot_count<3 && !(slot_count==0 && op_in==ON)).
- Pack rule: a legal non-ON opcode is written to slot slot_count, bits [4*slot_count+3 : 4*slot_count].
  - slot_count increments.
  - On the 4th slot, the full word pushes into the FIFO in the same edge and slot_count returns to 0.
- ON opcode: legal only as a standalone command.
  - slot_count==0: pushes word 16'h0000 (the sequencer's power-on/reset word); slot_count stays 0.
  - slot_count!=0: opcode is dropped, illegal pulses, partial word unchanged.
- Illegal opcode: accepted (op_ready obeys the rule above), dropped, illegal=1 for the next cycle; slot_count unchanged.
- Flush:
  - Pads the unfilled slots with NOOP (0010) and pushes the word; slot_count becomes 0.
  - flush with slot_count==0 is a no-op.
  - If the FIFO is full, flush is held pending (FLUSH_WAIT).
  - While pending, op_ready=0; the pad and push occur on the first cycle the FIFO is not full.
- Simultaneous opcode accept and flush: the opcode is packed first, then padding applies.
  - If the opcode completed the word, the flush adds nothing.
- Assembler FSM:
  - EMPTY: slot_count==0.
  - FILL: 1..3 slots filled.
  - FLUSH_WAIT: pending flush.
  - Transitions follow the rules above. EMPTY->FILL on a packed opcode; FILL->EMPTY on 4th slot or flush push; FILL->FLUSH_WAIT on flush with FIFO full.
- FIFO:
  - Pop on word_valid && word_ready.
  - Push and pop in the same cycle are allowed when not full; fifo_count is then unchanged.
  - No push when full.
  - word_out is the registered head; a push into an empty FIFO gives word_valid=1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: opcode completing a word -> word_valid 1 cycle later (if the FIFO was empty).
- Reset (asynchronous, any time, including mid-word or mid-flush):
  - slot_count=0, fifo_count=0, word_valid=0, word_out=0, illegal=0, FSM=EMPTY.
  - Partial word and buffered words are discarded.
  - op_ready=1 once reset deasserts.

Decomposition:
- Shared package halloween_pkg:
  - Opcode constants (OP_ON..OP_MOVEJAW), OP_W, SLOTS.
  - Function is_legal_op.
  - FSM state typedef (EMPTY, FILL, FLUSH_WAIT).
- One sub-module: program_fifo (parameterised width/depth synchronous FIFO, same clk/rst).
- Packing logic and FSM live in the top module.

Test Plan:
- Pack: feed FOG, GREEN, PURPLE, SCREAMING with word_ready=1 -> word_out=16'h8543, word_valid one cycle after 4th accept, slot_count back to 0.
- Flush: feed GREEN, ORANGE, pulse flush -> word_out=16'h2264, slot_count 0. Flush again at slot_count 0 -> no push.
- Legality:
  - op 0111 -> illegal pulses, slot_count unchanged, no word.
  - ON at slot_count 0 -> word 16'h0000.
  - ON at slot_count 2 -> illegal pulses, partial word intact.
- Backpressure:
  - word_ready=0, push 4 words -> fifo_count=4.
  - Feed 3 opcodes -> op_ready=0 at slot_count 3.
  - Flush in that state -> held pending, op_ready=0.
  - word_ready=1 for one cycle -> pending pad and push completes, fifo_count returns to 4.
- Simultaneous: pop and push in the same cycle at fifo_count=2 -> fifo_count stays 2, FIFO order preserved.
- Reset mid-word: 2 slots filled plus 1 buffered word, assert rst low asynchronously -> all outputs zero immediately; after release, feed BOO, GREEN, RESET, NOOP -> 16'h214A.
